// File: rtl/phase_sequencer.sv
// phase_sequencer
// Issues instructions as a walk of one-hot phase strobes. Each instruction
// starts at phase 0 and advances one phase per unstalled cycle. It retires
// after phase PHASES-1, or earlier when end_req is seen in any phase past 0.
// While run is high, instructions are issued back to back. With run low, a
// step in IDLE issues exactly one instruction.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high; returns to IDLE and clears the count
//   run          free-run enable
//   step         single-step request (honoured only in IDLE with run=0)
//   stall        hold the current phase for this cycle
//   end_req      finish the current instruction at the current phase
//   phase        one-hot phase strobe (all zero in IDLE)
//   phase_idx    binary index of the active phase (0 in IDLE)
//   busy         high while a phase is active
//   instr_done   one-cycle pulse in the cycle after a retirement
//   instr_count  retired-instruction count, wraps modulo 2^CNT_W
module phase_sequencer #(
  parameter int PHASES = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              stall,
  input  logic              end_req,
  output logic [PHASES-1:0] phase,
  output logic [3:0]        phase_idx,
  output logic              busy,
  output logic              instr_done,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(PHASES - 1);

  state_t             state_q, state_d;
  logic [3:0]         phase_idx_q, phase_idx_d;
  logic [PHASES-1:0]  phase_q, phase_d;
  logic               instr_done_q, instr_done_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               last_phase;

  always_comb begin
    state_d       = state_q;
    phase_idx_d   = phase_idx_q;
    instr_done_d  = 1'b0;
    instr_count_d = instr_count_q;
    // end_req is ignored in phase 0, so the shortest instruction is two phases.
    last_phase    = (phase_idx_q == LAST_IDX) ||
                    (end_req && (phase_idx_q != 4'd0));

    if (state_q == IDLE) begin
      // run and step both start phase 0, so their precedence needs no
      // separate handling here.
      if (run || step) begin
        state_d     = ACTIVE;
        phase_idx_d = '0;
      end
    end else if (!stall) begin
      if (last_phase) begin
        instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        instr_done_d  = 1'b1;
        phase_idx_d   = '0;
        if (!run) begin
          state_d = IDLE;
        end
      end else begin
        phase_idx_d = phase_idx_q + 4'd1;
      end
    end

    // Decode the strobe from the next index so that phase and phase_idx
    // are registered together and always agree.
    phase_d = '0;
    for (int unsigned k = 0; k < PHASES; k++) begin
      phase_d[k] = (state_d == ACTIVE) && (phase_idx_d == 4'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_idx_q   <= '0;
      phase_q       <= '0;
      instr_done_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_idx_q   <= phase_idx_d;
      phase_q       <= phase_d;
      instr_done_q  <= instr_done_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_idx   = phase_idx_q;
  assign busy        = (state_q == ACTIVE);
  assign instr_done  = instr_done_q;
  assign instr_count = instr_count_q;

endmodule
